// File: rtl/cfr_pkg.sv
// Shared types and default sizes for the CPW loader.
package cfr_pkg;

    localparam int CFR_DATA_WIDTH     = 16;
    localparam int CFR_CPW_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } cfr_state_e;

endpackage

// File: rtl/cfr_cpw_loader.sv
// Streams a cancellation-pulse waveform into CPW memory, one write per beat.
// Optional running XOR checksum output: define CFR_CPW_LOADER_CHECKSUM_EN.
module cfr_cpw_loader
    import cfr_pkg::*;
#(
    parameter int DATA_WIDTH     = CFR_DATA_WIDTH,
    parameter int CPW_ADDR_WIDTH = CFR_CPW_ADDR_WIDTH
) (
    input  logic                      ctrl_clk,
    input  logic                      ctrl_rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic [DATA_WIDTH-1:0]     s_data_q,
    input  logic                      s_last,
    output logic                      ctrl_cpw_wr_en,
    output logic [CPW_ADDR_WIDTH-1:0] ctrl_cpw_wr_addr,
    output logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_i,
    output logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_q,
    output logic                      busy,
    output logic                      done,
    output logic                      error
`ifdef CFR_CPW_LOADER_CHECKSUM_EN
    ,
    output logic [2*DATA_WIDTH-1:0]   checksum
`endif
);

    cfr_state_e                r_state;
    cfr_state_e                w_next;
    logic [CPW_ADDR_WIDTH-1:0] r_cnt;
    logic                      r_wr_en;
    logic [CPW_ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0]     r_wr_i;
    logic [DATA_WIDTH-1:0]     r_wr_q;
    logic                      r_done;
    logic                      r_error;

    logic w_ready;
    logic w_accept;
    logic w_load_acc;
    logic w_start;
    logic w_at_end;

    // abort (and reset) must close the handshake in the same cycle
    assign w_ready    = (r_state != ST_IDLE) && !abort && !ctrl_rst;
    assign w_accept   = s_valid && w_ready;
    assign w_load_acc = w_accept && (r_state == ST_LOAD);
    assign w_start    = (r_state == ST_IDLE) && start && !abort;
    assign w_at_end   = (r_cnt == {CPW_ADDR_WIDTH{1'b1}});

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (s_last)        w_next = ST_IDLE;
                    else if (w_at_end) w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_accept && s_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_i    <= '0;
            r_wr_q    <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_en   <= w_load_acc;
            r_wr_addr <= w_load_acc ? r_cnt : '0;
            r_wr_i    <= w_load_acc ? s_data_i : '0;
            r_wr_q    <= w_load_acc ? s_data_q : '0;
            r_done    <= w_load_acc && s_last && w_at_end;
            if (w_start) begin
                r_cnt   <= '0;
                r_error <= 1'b0;
            end else if (w_load_acc) begin
                // early last or missing last on the final slot
                if (s_last != w_at_end) r_error <= 1'b1;
                if (!s_last && !w_at_end) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef CFR_CPW_LOADER_CHECKSUM_EN
    logic [2*DATA_WIDTH-1:0] r_cks;

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            r_cks <= '0;
        end else if (w_start) begin
            r_cks <= '0;
        end else if (w_load_acc) begin
            r_cks <= r_cks ^ {s_data_i, s_data_q};
        end
    end

    assign checksum = r_cks;
`endif

    assign s_ready            = w_ready;
    assign ctrl_cpw_wr_en     = r_wr_en;
    assign ctrl_cpw_wr_addr   = r_wr_addr;
    assign ctrl_cpw_wr_data_i = r_wr_i;
    assign ctrl_cpw_wr_data_q = r_wr_q;
    assign busy               = (r_state != ST_IDLE);
    assign done               = r_done;
    assign error              = r_error;

endmodule

// File: tb/tb_cfr_cpw_loader.sv
// Scoreboard bench for cfr_cpw_loader against a beat-level reference model.
// Checksum checks are compiled in with CFR_CPW_LOADER_CHECKSUM_EN.
module tb_cfr_cpw_loader;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int N  = 256;

    logic          ctrl_clk = 1'b0;
    logic          ctrl_rst = 1'b1;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data_i = '0;
    logic [DW-1:0] s_data_q = '0;
    logic          s_last   = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_i;
    logic [DW-1:0] wr_q;
    logic          busy;
    logic          done;
    logic          error;
`ifdef CFR_CPW_LOADER_CHECKSUM_EN
    logic [2*DW-1:0] checksum;
`endif

    cfr_cpw_loader #(.DATA_WIDTH(DW), .CPW_ADDR_WIDTH(AW)) dut (
        .ctrl_clk           (ctrl_clk),
        .ctrl_rst           (ctrl_rst),
        .start              (start),
        .abort              (abort),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .s_data_i           (s_data_i),
        .s_data_q           (s_data_q),
        .s_last             (s_last),
        .ctrl_cpw_wr_en     (wr_en),
        .ctrl_cpw_wr_addr   (wr_addr),
        .ctrl_cpw_wr_data_i (wr_i),
        .ctrl_cpw_wr_data_q (wr_q),
        .busy               (busy),
        .done               (done),
        .error              (error)
`ifdef CFR_CPW_LOADER_CHECKSUM_EN
        ,
        .checksum           (checksum)
`endif
    );

    always #5 ctrl_clk = ~ctrl_clk;

    typedef struct {
        int          addr;
        logic [DW-1:0] di;
        logic [DW-1:0] dq;
        bit          dn;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;

    // reference model: 0 idle, 1 loading, 2 flushing
    int              m_mode = 0;
    int              m_k    = 0;
    bit              m_err  = 1'b0;
    bit              m_done = 1'b0;
    logic [2*DW-1:0] m_cks  = '0;

    always @(posedge ctrl_clk) cyc++;

    always @(negedge ctrl_clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            checks++;
            if (wr_en) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d i=%h q=%h, none expected",
                             wr_addr, wr_i, wr_q);
                end else begin
                    e = sb.pop_front();
                    if (int'(wr_addr) != e.addr || wr_i !== e.di || wr_q !== e.dq ||
                        done !== e.dn || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write: got addr=%0d i=%h q=%h done=%0b cyc=%0d, want addr=%0d i=%h q=%h done=%0b cyc=%0d",
                                 wr_addr, wr_i, wr_q, done, cyc,
                                 e.addr, e.di, e.dq, e.dn, e.cyc);
                    end
                end
            end else if (wr_addr !== '0 || wr_i !== '0 || wr_q !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: addr=%0d i=%h q=%h done=%0b, want all 0",
                         wr_addr, wr_i, wr_q, done);
            end
        end
    end

    task automatic model_beat(input logic [DW-1:0] di, input logic [DW-1:0] dq,
                              input bit last);
        exp_t e;
        if (m_mode == 1) begin
            e.addr = m_k;
            e.di   = di;
            e.dq   = dq;
            e.dn   = (m_k == N - 1) && last;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            m_cks ^= {di, dq};
            if (m_k == N - 1) begin
                if (last) begin
                    m_mode = 0;
                    m_done = 1'b1;
                end else begin
                    m_err  = 1'b1;
                    m_mode = 2;
                end
            end else if (last) begin
                m_err  = 1'b1;
                m_mode = 0;
            end else begin
                m_k++;
            end
        end else if (m_mode == 2) begin
            if (last) m_mode = 0;
        end
    endtask

    // dmode: 0 ramp I=b Q=-b, 1 random, 2 I=Q=1, 3 as 2 with beat0 I=3
    task automatic do_load(input int nb, input int last_at, input bit rnd,
                           input int dmode, input int abort_at, input int rst_at);
        int b;
        int guard;
        bit stop;
        bit exp_rdy;
        @(posedge ctrl_clk);
        #1;
        start = 1'b1;
        @(negedge ctrl_clk);
        m_mode = 1;
        m_k    = 0;
        m_err  = 1'b0;
        m_done = 1'b0;
        m_cks  = '0;
        @(posedge ctrl_clk);
        #1;
        start = 1'b0;
        b     = 0;
        guard = 0;
        stop  = 1'b0;
        while (!stop && b < nb && guard < 4000) begin
            guard++;
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            case (dmode)
                0: begin
                    s_data_i = DW'(b);
                    s_data_q = DW'(-b);
                end
                1: begin
                    s_data_i = DW'($urandom);
                    s_data_q = DW'($urandom);
                end
                2: begin
                    s_data_i = 16'h0001;
                    s_data_q = 16'h0001;
                end
                default: begin
                    s_data_i = (b == 0) ? 16'h0003 : 16'h0001;
                    s_data_q = 16'h0001;
                end
            endcase
            s_last   = (b == last_at);
            abort    = s_valid && (b == abort_at);
            ctrl_rst = s_valid && (b == rst_at);
            start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge ctrl_clk);
            exp_rdy = (m_mode != 0) && !abort && !ctrl_rst;
            checks++;
            if (s_ready !== exp_rdy) begin
                errors++;
                $display("FAIL ready: beat=%0d got %0b want %0b", b, s_ready, exp_rdy);
            end
            if (abort || ctrl_rst) begin
                stop   = 1'b1;
                m_mode = 0;
                if (ctrl_rst) begin
                    m_err = 1'b0;
                    m_cks = '0;
                end
            end else if (s_valid && exp_rdy) begin
                model_beat(s_data_i, s_data_q, s_last);
                b++;
            end
            @(posedge ctrl_clk);
            #1;
        end
        checks++;
        if (guard >= 4000) begin
            errors++;
            $display("FAIL load_timeout: beats=%0d of %0d", b, nb);
        end
        start    = 1'b0;
        abort    = 1'b0;
        ctrl_rst = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        s_data_i = '0;
        s_data_q = '0;
        @(negedge ctrl_clk);
        checks++;
        if (busy !== 1'b0 || error !== m_err || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL end_state: busy=%0b error=%0b ready=%0b, want busy=0 error=%0b ready=0",
                     busy, error, s_ready, m_err);
        end
`ifdef CFR_CPW_LOADER_CHECKSUM_EN
        if (m_done) begin
            checks++;
            if (checksum !== m_cks) begin
                errors++;
                $display("FAIL checksum: got %h want %h", checksum, m_cks);
            end
        end
`endif
        repeat (2) @(negedge ctrl_clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding, want 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        repeat (3) @(posedge ctrl_clk);
        #1;
        ctrl_rst = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_i !== '0 || wr_q !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: en=%0b addr=%0d busy=%0b done=%0b err=%0b rdy=%0b, want all 0",
                     wr_en, wr_addr, busy, done, error, s_ready);
        end
        mon_en = 1'b1;

        do_load(256, 255, 1'b0, 0, -1, -1);
        do_load(256, 255, 1'b1, 1, -1, -1);
        do_load(100, 99, 1'b0, 1, -1, -1);

        // start together with abort in idle must not begin a load or clear error
        @(posedge ctrl_clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge ctrl_clk);
        @(posedge ctrl_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL start_abort: busy=%0b error=%0b, want busy=0 error=1", busy, error);
        end

        do_load(300, 299, 1'b0, 1, -1, -1);
        do_load(256, 255, 1'b0, 0, 50, -1);
        do_load(256, 255, 1'b0, 1, -1, 137);
        do_load(256, 255, 1'b1, 1, -1, -1);

`ifdef CFR_CPW_LOADER_CHECKSUM_EN
        do_load(256, 255, 1'b0, 2, -1, -1);
        checks++;
        if (checksum !== 32'h0000_0000) begin
            errors++;
            $display("FAIL checksum_ones: got %h want 00000000", checksum);
        end
        do_load(256, 255, 1'b0, 3, -1, -1);
        checks++;
        if (checksum !== 32'h0002_0000) begin
            errors++;
            $display("FAIL checksum_beat0: got %h want 00020000", checksum);
        end
`endif

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
